// File: rtl/sound_play4_if.sv
// Control and sample-buffer bundle between the frame controller/buffer and sound_play4.
//   master: frame controller + buffer side (drives start/abort/word_count/q)
//   slave : sound_play4 side (drives rdaddress/busy/done/bytes_sent)
interface sound_play4_if;
    localparam int unsigned WC_W   = 10;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BS_W   = 14;

    logic              start;
    logic              abort;
    logic [WC_W-1:0]   word_count;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic              busy;
    logic              done;
    logic [BS_W-1:0]   bytes_sent;

    modport master (
        output start, abort, word_count, q,
        input  rdaddress, busy, done, bytes_sent
    );

    modport slave (
        input  start, abort, word_count, q,
        output rdaddress, busy, done, bytes_sent
    );
endinterface

// File: rtl/sound_play4.sv
// sound_play4: fetches 16-bit sound words from a dual-port sample buffer and
// sends each as two 8N1 frames (low byte first, LSB first) on Tx.
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   bus        sound_play4_if.slave: start/abort/word_count in, q in,
//              rdaddress/busy/done/bytes_sent out (all registered)
//   Tx         registered serial output, idles high
// Parameters:
//   length     bit period is length+1 clocks (matches the receiver)
//   RD_LAT     buffer read latency in clocks, 1..3
module sound_play4 #(
    parameter int unsigned length = 48,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    sound_play4_if.slave  bus,
    output logic          Tx
);

    localparam int unsigned CNT_W  = (length == 0) ? 1 : $clog2(length + 1);
    localparam int unsigned WAIT_W = 2;
    localparam int unsigned WC_W   = 10;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BS_W   = 14;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] START_BIT = 3'd2;
    localparam logic [2:0] DATA_BIT  = 3'd3;
    localparam logic [2:0] STOP_BIT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              hi_q, hi_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [WC_W-1:0]   remain_q, remain_d;
    logic              abort_pend_q, abort_pend_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic [BS_W-1:0]   bytes_q, bytes_d;

    logic              bit_end;
    logic [2:0]        nxt_idx;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            wait_q       <= '0;
            hi_q         <= 1'b0;
            hold_q       <= '0;
            remain_q     <= '0;
            abort_pend_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdaddr_q     <= '0;
            bytes_q      <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            wait_q       <= wait_d;
            hi_q         <= hi_d;
            hold_q       <= hold_d;
            remain_q     <= remain_d;
            abort_pend_q <= abort_pend_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rdaddr_q     <= rdaddr_d;
            bytes_q      <= bytes_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        wait_d       = wait_q;
        hi_d         = hi_q;
        hold_d       = hold_q;
        remain_d     = remain_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rdaddr_d     = rdaddr_q;
        bytes_d      = bytes_q;
        // Abort only counts while a transfer is running
        abort_pend_d = abort_pend_q | (bus.abort & busy_q);

        bit_end = (bit_cnt_q == CNT_W'(length));
        nxt_idx = 3'(bit_idx_q + 3'd1);

        case (state_q)
            IDLE: begin
                tx_d         = 1'b1;
                abort_pend_d = 1'b0;
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        remain_d = bus.word_count;
                        rdaddr_d = '0;
                        bytes_d  = '0;
                        busy_d   = 1'b1;
                        wait_d   = '0;
                        state_d  = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            FETCH: begin
                tx_d = 1'b1;
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    hold_d    = bus.q;
                    hi_d      = 1'b0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = START_BIT;
                end else begin
                    wait_d = WAIT_W'(wait_q + 1'b1);
                end
            end

            START_BIT: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = hold_q[{hi_q, 3'd0}];
                    state_d   = DATA_BIT;
                end else begin
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                end
            end

            DATA_BIT: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = hold_q[{hi_q, nxt_idx}];
                    end
                end else begin
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                end
            end

            STOP_BIT: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bytes_d   = BS_W'(bytes_q + 1'b1);
                    if (!hi_q) begin
                        // High byte follows the low byte with no idle gap
                        hi_d    = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START_BIT;
                    end else begin
                        remain_d = WC_W'(remain_q - 1'b1);
                        if ((remain_q == WC_W'(1)) || abort_pend_d) begin
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            abort_pend_d = 1'b0;
                            state_d      = IDLE;
                        end else begin
                            rdaddr_d = ADDR_W'(rdaddr_q + 1'b1);
                            wait_d   = '0;
                            state_d  = FETCH;
                        end
                    end
                end else begin
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign Tx             = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rdaddress  = rdaddr_q;
    assign bus.bytes_sent = bytes_q;

endmodule
